// File: rtl/blake2_pkg.sv
// Shared types and constants for the BLAKE2b input front-end.
package blake2_pkg;

   localparam int BUS_WIDTH   = 32;
   localparam int BLOCK_WIDTH = 1024;

   typedef struct packed {
      logic [BUS_WIDTH-1:0] data;
      logic                 last;
      logic [2:0]           nbytes;
   } in_entry_t;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      REQ,
      GAP
   } ibuf_state_t;

   // Non-final beats always carry a full word; final beats saturate at 4 bytes.
   function automatic logic [2:0] entry_nbytes(input logic last, input logic [2:0] nbytes);
      if (!last)
         return 3'd4;
      if (nbytes > 3'd4)
         return 3'd4;
      return nbytes;
   endfunction

endpackage

// File: rtl/blake2_input_buffer_if.sv
// Host-side ready/valid message stream into the BLAKE2b input buffer.
interface blake2_input_buffer_if #(
   parameter int BUS_WIDTH = blake2_pkg::BUS_WIDTH
);
   logic [BUS_WIDTH-1:0] s_data;
   logic                 s_valid;
   logic                 s_last;
   logic [2:0]           s_nbytes;
   logic                 s_ready;

   modport master (
      output s_data, s_valid, s_last, s_nbytes,
      input  s_ready
   );

   modport slave (
      input  s_data, s_valid, s_last, s_nbytes,
      output s_ready
   );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; pointers wrap modulo DEPTH (power of two).
module sync_fifo #(
   parameter int WIDTH = 36,
   parameter int DEPTH = 32,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic [AW:0]      count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/blake2_input_buffer.sv
// Buffers host message words and replays them to the BLAKE2b controller as
// din/valid_in beats followed by a single new_hash_request pulse.
module blake2_input_buffer
   import blake2_pkg::*;
#(
   parameter int BUS_WIDTH = blake2_pkg::BUS_WIDTH,
   parameter int DEPTH     = 32,
   parameter int AW        = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 reset,
   blake2_input_buffer_if.slave host,
   input  logic                 ctrl_ready,
   output logic [BUS_WIDTH-1:0] din,
   output logic                 valid_in,
   output logic                 new_hash_request,
   output logic [2:0]           last_nbytes,
   output logic                 buf_empty,
   output logic                 buf_full,
   output logic [AW:0]          level
);

   typedef struct packed {
      logic [BUS_WIDTH-1:0] data;
      logic                 last;
      logic [2:0]           nbytes;
   } entry_t;

   entry_t      wr_entry;
   entry_t      head;
   ibuf_state_t state, state_n;
   logic        pend, pend_n;
   logic [2:0]  lnb_n;
   logic        pop;
   logic        take;
   logic        load_din;

   assign wr_entry = '{data:   host.s_data,
                       last:   host.s_last,
                       nbytes: entry_nbytes(host.s_last, host.s_nbytes)};

   sync_fifo #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (host.s_valid),
      .wdata (wr_entry),
      .pop   (pop),
      .rdata (head),
      .count (level),
      .full  (buf_full),
      .empty (buf_empty)
   );

   assign host.s_ready     = !buf_full;
   assign valid_in         = (state == DATA);
   assign new_hash_request = (state == REQ);

   // Pops only happen from IDLE or a non-final DATA beat, so a following
   // message can never leak out before the GAP cycle has elapsed.
   always_comb begin
      state_n  = state;
      pend_n   = pend;
      lnb_n    = last_nbytes;
      pop      = 1'b0;
      take     = 1'b0;
      load_din = 1'b0;
      case (state)
         IDLE: take = !buf_empty && ctrl_ready;
         DATA: begin
            if (pend)
               state_n = REQ;
            else if (!buf_empty && ctrl_ready)
               take = 1'b1;
            else
               state_n = IDLE;
         end
         REQ: begin
            pend_n  = 1'b0;
            state_n = GAP;
         end
         GAP:     state_n = IDLE;
         default: state_n = IDLE;
      endcase
      if (take) begin
         pop    = 1'b1;
         pend_n = head.last && (head.nbytes != 3'd0);
         if (head.last)
            lnb_n = head.nbytes;
         if (head.last && (head.nbytes == 3'd0)) begin
            state_n = REQ;
         end else begin
            state_n  = DATA;
            load_din = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         pend        <= 1'b0;
         din         <= '0;
         last_nbytes <= '0;
      end else begin
         state       <= state_n;
         pend        <= pend_n;
         last_nbytes <= lnb_n;
         if (load_din)
            din <= head.data;
      end
   end

endmodule

// File: tb/tb_blake2_input_buffer.sv
// Scoreboard bench: stimulus queues expected beats/requests, a negedge monitor checks them.
module tb_blake2_input_buffer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ctrl_ready = 1'b0;
   logic [31:0] din;
   logic        valid_in;
   logic        new_hash_request;
   logic [2:0]  last_nbytes;
   logic        buf_empty;
   logic        buf_full;
   logic [5:0]  level;

   int vectors = 0;
   int miscompares = 0;

   typedef struct packed {
      logic        is_req;
      logic [31:0] val;
   } exp_t;

   exp_t q[$];
   logic prev_req = 1'b0;

   blake2_input_buffer_if #(.BUS_WIDTH(32)) hs ();

   blake2_input_buffer #(
      .BUS_WIDTH (32),
      .DEPTH     (32),
      .AW        (5)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .host             (hs.slave),
      .ctrl_ready       (ctrl_ready),
      .din              (din),
      .valid_in         (valid_in),
      .new_hash_request (new_hash_request),
      .last_nbytes      (last_nbytes),
      .buf_empty        (buf_empty),
      .buf_full         (buf_full),
      .level            (level)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic exp_word(input logic [31:0] v);
      q.push_back('{is_req: 1'b0, val: v});
   endtask

   task automatic exp_req(input logic [2:0] nb);
      q.push_back('{is_req: 1'b1, val: 32'(nb)});
   endtask

   // Called at posedge+1; returns at posedge+1 after the beat is accepted.
   task automatic send(input logic [31:0] d, input logic last, input logic [2:0] nb);
      int n = 0;
      hs.s_data   = d;
      hs.s_last   = last;
      hs.s_nbytes = nb;
      hs.s_valid  = 1'b1;
      while (!hs.s_ready && n < 1000) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 1000)
         check("send_timeout", 32'd1, 32'd0);
      @(posedge clk);
      #1;
      hs.s_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((q.size() != 0 || !buf_empty) && n < 2000) begin
         @(posedge clk);
         n++;
      end
      if (n >= 2000)
         check("drain_timeout", 32'd1, 32'd0);
      repeat (4) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         prev_req = 1'b0;
      end else begin
         if (prev_req)
            check("gap_idle", {30'd0, valid_in, new_hash_request}, 32'd0);
         if (valid_in && new_hash_request)
            check("exclusive", 32'd1, 32'd0);
         if (valid_in || new_hash_request) begin
            if (q.size() == 0) begin
               check("unexpected_output", {30'd0, valid_in, new_hash_request}, 32'd0);
            end else begin
               e = q.pop_front();
               check("kind", {31'd0, new_hash_request}, {31'd0, e.is_req});
               if (new_hash_request)
                  check("last_nbytes", 32'(last_nbytes), e.val);
               else
                  check("din", din, e.val);
            end
         end
         prev_req = new_hash_request;
      end
   end

   initial begin
      hs.s_data   = '0;
      hs.s_valid  = 1'b0;
      hs.s_last   = 1'b0;
      hs.s_nbytes = '0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_valid_in", {31'd0, valid_in}, 32'd0);
      check("rst_req", {31'd0, new_hash_request}, 32'd0);
      check("rst_din", din, 32'd0);
      check("rst_last_nbytes", 32'(last_nbytes), 32'd0);
      check("rst_empty", {31'd0, buf_empty}, 32'd1);
      check("rst_full", {31'd0, buf_full}, 32'd0);
      check("rst_level", 32'(level), 32'd0);
      check("rst_s_ready", {31'd0, hs.s_ready}, 32'd1);
      reset = 1'b0;
      ctrl_ready = 1'b1;
      @(posedge clk);
      #1;

      // Empty message
      exp_req(3'd0);
      send(32'hDEAD_BEEF, 1'b1, 3'd0);
      drain();

      // 4-byte message with explicit latency check
      exp_word(32'h1111_1111);
      exp_req(3'd4);
      send(32'h1111_1111, 1'b1, 3'd4);
      @(negedge clk);
      check("lat_not_yet", {31'd0, valid_in}, 32'd0);
      @(negedge clk);
      check("lat_valid", {31'd0, valid_in}, 32'd1);
      @(negedge clk);
      check("lat_req", {31'd0, new_hash_request}, 32'd1);
      @(posedge clk);
      #1;
      drain();
      check("din_hold", din, 32'h1111_1111);

      // 124-byte message, nbytes clamp on last beat (7 -> 4)
      for (int i = 1; i <= 31; i++)
         exp_word(32'(i) * 32'h1111_1111);
      exp_req(3'd4);
      for (int i = 1; i <= 31; i++)
         send(32'(i) * 32'h1111_1111, (i == 31), (i == 31) ? 3'd7 : 3'd1);
      drain();

      // Backpressure: fill to full, then release
      ctrl_ready = 1'b0;
      for (int i = 0; i < 33; i++)
         exp_word(32'hA000_0000 + 32'(i));
      exp_req(3'd4);
      for (int i = 0; i < 32; i++)
         send(32'hA000_0000 + 32'(i), 1'b0, 3'd0);
      check("full_level", 32'(level), 32'd32);
      check("full_flag", {31'd0, buf_full}, 32'd1);
      check("full_s_ready", {31'd0, hs.s_ready}, 32'd0);
      fork
         send(32'hA000_0020, 1'b1, 3'd4);
         begin
            repeat (2) @(posedge clk);
            #1;
            ctrl_ready = 1'b1;
            @(negedge clk);
            check("still_full", {31'd0, hs.s_ready}, 32'd0);
            @(negedge clk);
            check("ready_after_pop", {31'd0, hs.s_ready}, 32'd1);
            check("level_after_pop", 32'(level), 32'd31);
         end
      join
      drain();

      // Simultaneous push/pop at level 5, then 3*DEPTH words across wrap
      ctrl_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         exp_word(32'hB000_0000 + 32'(i));
         send(32'hB000_0000 + 32'(i), 1'b0, 3'd0);
      end
      check("level5", 32'(level), 32'd5);
      for (int i = 0; i < 96; i++)
         exp_word(32'hC000_0000 | 32'(i));
      exp_req(3'd3);
      fork
         begin
            ctrl_ready = 1'b1;
            for (int i = 0; i < 96; i++)
               send(32'hC000_0000 | 32'(i), (i == 95), 3'd3);
         end
         begin
            repeat (10) begin
               @(negedge clk);
               check("level_steady", 32'(level), 32'd5);
            end
         end
      join
      drain();

      // Reset mid-message with 10 words buffered
      ctrl_ready = 1'b0;
      for (int i = 0; i < 10; i++)
         send(32'hD000_0000 + 32'(i), 1'b0, 3'd0);
      check("level10", 32'(level), 32'd10);
      exp_word(32'hD000_0000);
      exp_word(32'hD000_0001);
      ctrl_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("mid_rst_valid_in", {31'd0, valid_in}, 32'd0);
      check("mid_rst_din", din, 32'd0);
      check("mid_rst_level", 32'(level), 32'd0);
      check("mid_rst_empty", {31'd0, buf_empty}, 32'd1);
      check("mid_rst_s_ready", {31'd0, hs.s_ready}, 32'd1);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("post_rst_level", 32'(level), 32'd0);
      check("leftover_expect", 32'(q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
